// File: rtl/pc_pkg.sv
// Shared types for the fetch program counter and its return-address stack.
package pc_pkg;

  localparam int PC_ADDR_W = 32;

  typedef logic [PC_ADDR_W-1:0] addr_t;

  // Source of the next fetch address, listed from lowest to highest priority.
  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_SEQ,
    SRC_JUMP,
    SRC_RET,
    SRC_BRANCH,
    SRC_TRAP
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push grows, pop shrinks, push+pop replaces top.
// A push into a full stack overwrites the oldest entry and sets a sticky overflow flag.
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_replace;
  logic              do_push;
  logic              do_pop;
  logic [PTR_W-1:0]  wr_ptr;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(RAS_DEPTH));
  assign top   = mem[top_ptr];

  // Replacing the top of an empty stack degenerates into an ordinary push.
  assign do_replace = push && pop && !empty;
  assign do_push    = push && !do_replace;
  assign do_pop     = pop && !push && !empty;
  assign wr_ptr     = do_replace ? top_ptr : top_ptr + PTR_W'(1);

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push || do_replace) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_ptr  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (do_push) begin
      top_ptr <= top_ptr + PTR_W'(1);
      if (full) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end else if (do_pop) begin
      top_ptr <= top_ptr - PTR_W'(1);
      count   <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch program counter with trap/branch/return/jump redirects and a return-address stack.
// All outputs are registered; pc changes become visible the cycle after the deciding edge.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              STEP      = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = '0,
  parameter int              RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap,
  input  logic              do_branch,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              do_jump,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic              do_call,
  input  logic              do_return,
  input  logic [ADDR_W-1:0] ret_fallback,
  input  logic              consumed_inst,
  output logic [ADDR_W-1:0] pc,
  output logic              redirect,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow
);

  pc_src_e           src;
  logic [ADDR_W-1:0] link;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] next_pc;
  logic              ras_push;
  logic              ras_pop;

  assign link = pc + ADDR_W'(STEP);

  always_comb begin
    src = SRC_HOLD;
    if (trap)               src = SRC_TRAP;
    else if (do_branch)     src = SRC_BRANCH;
    else if (do_return)     src = SRC_RET;
    else if (do_jump)       src = SRC_JUMP;
    else if (consumed_inst) src = SRC_SEQ;
  end

  // Only the winning source may touch the stack; a return that wins alongside
  // jump+call is a co-routine swap and replaces the top with the new link.
  assign ras_push = do_jump && do_call && ((src == SRC_JUMP) || (src == SRC_RET));
  assign ras_pop  = (src == SRC_RET);

  always_comb begin
    next_pc = pc;
    case (src)
      SRC_TRAP:   next_pc = TRAP_VEC;
      SRC_BRANCH: next_pc = branch_address;
      SRC_RET:    next_pc = ras_empty ? ret_fallback : ras_top;
      SRC_JUMP:   next_pc = jump_address;
      SRC_SEQ:    next_pc = link;
      default:    next_pc = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_VEC;
      redirect <= 1'b0;
    end else begin
      pc       <= next_pc;
      redirect <= (src != SRC_HOLD) && (src != SRC_SEQ);
    end
  end

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow)
  );

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: directed scenarios plus random traffic against a
// queue-based model of the pc and return-address stack.
module tb_pc_unit_ras;

  localparam int          AW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam logic [31:0] TV    = 32'h0000_0080;
  localparam int          W     = AW + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trap = 1'b0, do_branch = 1'b0, do_jump = 1'b0, do_call = 1'b0;
  logic          do_return = 1'b0, consumed_inst = 1'b0;
  logic [AW-1:0] branch_address = '0, jump_address = '0, ret_fallback = '0;
  logic [AW-1:0] pc;
  logic          redirect, ras_empty, ras_full, ras_overflow;
  logic [W-1:0]  dut_vec;

  int checks   = 0;
  int failures = 0;

  // Model state: the stack is a queue whose back is the top.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_ras[$];
  logic          m_ovf;
  logic [W-1:0]  exp_q[$];

  pc_unit_ras #(
    .ADDR_W(AW), .STEP(4), .RESET_VEC(RV), .TRAP_VEC(TV), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .trap(trap), .do_branch(do_branch),
    .branch_address(branch_address), .do_jump(do_jump), .jump_address(jump_address),
    .do_call(do_call), .do_return(do_return), .ret_fallback(ret_fallback),
    .consumed_inst(consumed_inst), .pc(pc), .redirect(redirect),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow)
  );

  assign dut_vec = {pc, redirect, ras_empty, ras_full, ras_overflow};

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got pc=%h red=%b emp=%b full=%b ovf=%b, expected pc=%h red=%b emp=%b full=%b ovf=%b",
               name, act[W-1:4], act[3], act[2], act[1], act[0],
               exp[W-1:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [W-1:0] model_vec(input logic red);
    return {m_pc, red, m_ras.size() == 0, m_ras.size() == DEPTH, m_ovf};
  endfunction

  function automatic void model_push(input logic [AW-1:0] a);
    if (m_ras.size() == DEPTH) begin
      void'(m_ras.pop_front());
      m_ovf = 1'b1;
    end
    m_ras.push_back(a);
  endfunction

  // Monitor: every cycle with a pending expectation, compare just after the edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) check("cycle", dut_vec, exp_q.pop_front());
  end

  task automatic step(input logic t, input logic b, input logic [AW-1:0] ba,
                      input logic j, input logic [AW-1:0] ja, input logic c,
                      input logic r, input logic [AW-1:0] fb, input logic cons);
    logic [AW-1:0] link;
    logic [AW-1:0] tgt;
    logic          red;
    @(negedge clk);
    trap = t; do_branch = b; branch_address = ba; do_jump = j; jump_address = ja;
    do_call = c; do_return = r; ret_fallback = fb; consumed_inst = cons;
    link = m_pc + 32'd4;
    red  = 1'b1;
    if (t) m_pc = TV;
    else if (b) m_pc = ba;
    else if (r) begin
      tgt = (m_ras.size() != 0) ? m_ras[$] : fb;
      if (j && c) begin
        if (m_ras.size() == 0) m_ras.push_back(link);
        else m_ras[m_ras.size()-1] = link;
      end else if (m_ras.size() != 0) begin
        void'(m_ras.pop_back());
      end
      m_pc = tgt;
    end else if (j) begin
      if (c) model_push(link);
      m_pc = ja;
    end else begin
      red = 1'b0;
      if (cons) m_pc = link;
    end
    exp_q.push_back(model_vec(red));
  endtask

  task automatic idle();      step(0, 0, '0, 0, '0, 0, 0, '0, 0); endtask
  task automatic consume();   step(0, 0, '0, 0, '0, 0, 0, '0, 1); endtask
  task automatic branch(input logic [AW-1:0] a); step(0, 1, a, 0, '0, 0, 0, '0, 0); endtask
  task automatic call(input logic [AW-1:0] a);   step(0, 0, '0, 1, a, 1, 0, '0, 0); endtask
  task automatic ret(input logic [AW-1:0] fb);   step(0, 0, '0, 0, '0, 0, 1, fb, 0); endtask

  // Reset is pulsed between edges; pc must reset without waiting for a clock.
  task automatic pulse_reset();
    @(negedge clk);
    trap = 0; do_branch = 0; do_jump = 0; do_call = 0; do_return = 0; consumed_inst = 0;
    #2 rst = 1'b0;
    m_pc = RV; m_ras.delete(); m_ovf = 1'b0;
    #1 check("rst_async", dut_vec, model_vec(1'b0));
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_release", dut_vec, model_vec(1'b0));
  endtask

  initial begin
    m_pc = RV; m_ovf = 1'b0;
    pulse_reset();

    // Sequential fetch from the reset vector.
    repeat (3) consume();

    // Call from 0x200 to 0x400, run a little, return to the link.
    branch(32'h200);
    call(32'h400);
    consume(); consume();
    ret(32'hBAD0_0000);
    idle();

    // Trap beats branch and return; the pending call entry survives.
    branch(32'h200);
    call(32'h400);
    step(1, 1, 32'h300, 0, '0, 0, 1, 32'h1234, 0);
    ret(32'h1234);
    idle();

    // Five nested calls into a 4-deep stack, then five returns.
    for (int i = 0; i < 5; i++) call(32'h1000 * (i + 1));
    for (int i = 0; i < 5; i++) ret(32'hDEAD_0000);

    // Co-routine swap on empty and non-empty stacks, squashed call, lone do_call.
    step(0, 0, '0, 1, 32'h5000, 1, 1, 32'h6000, 0);
    step(0, 0, '0, 1, 32'h7000, 1, 1, 32'h6000, 0);
    step(0, 1, 32'h8000, 1, 32'h9000, 1, 0, '0, 0);
    step(0, 0, '0, 0, '0, 1, 0, '0, 1);
    ret(32'h0);
    idle();

    // Sequential wrap at the top of the address space.
    branch(32'hFFFF_FFFC);
    consume();
    consume();

    // Reset in the middle of activity discards the stack.
    repeat (3) call($urandom);
    pulse_reset();

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom,
                $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 1) == 1,
                $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 1) == 1);
    end

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
